// File: rtl/pwm_ctrl_pkg.sv
// Shared state encodings and constants for the breathing-LED PWM sequencer.
package pwm_ctrl_pkg;

   localparam int STATE_W   = 3;
   localparam int US_PER_MS = 1000;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 3'd0,
      RAMP_UP = 3'd1,
      HOLD_HI = 3'd2,
      RAMP_DN = 3'd3,
      HOLD_LO = 3'd4
   } state_t;

endpackage

// File: rtl/pwm_timebase.sv
// us / step / ms tick generator; all counters restart from zero whenever clr is high.
module pwm_timebase
   import pwm_ctrl_pkg::*;
#(
   parameter int CLK_MHZ = 5,
   parameter int STEP_US = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic us_tick,
   output logic step_tick,
   output logic ms_tick
);

   localparam int US_W   = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
   localparam int STEP_W = (STEP_US > 1) ? $clog2(STEP_US) : 1;
   localparam int MS_W   = $clog2(US_PER_MS);

   logic [US_W-1:0]   us_cnt;
   logic [STEP_W-1:0] step_cnt;
   logic [MS_W-1:0]   ms_cnt;

   assign us_tick   = (us_cnt == US_W'(CLK_MHZ - 1));
   assign step_tick = us_tick && (step_cnt == STEP_W'(STEP_US - 1));
   assign ms_tick   = us_tick && (ms_cnt == MS_W'(US_PER_MS - 1));

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         us_cnt   <= '0;
         step_cnt <= '0;
         ms_cnt   <= '0;
      end else begin
         us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
         if (us_tick) begin
            step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
            ms_cnt   <= ms_tick   ? '0 : ms_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-LED sequencer: ramp up, hold, ramp down, hold, repeat until stopped.
// Define PWM_GAMMA_EN for a square-law duty curve; default build is linear.
module pwm_breath_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int CLK_MHZ  = 5,
   parameter int PWM_BITS = 8,
   parameter int STEP_US  = 4,
   parameter int HOLD_MS  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   output logic                busy,
   output logic [STATE_W-1:0]  state,
   output logic [PWM_BITS-1:0] duty,
   output logic                cycle_done,
   output logic                pwm_sig
);

   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam int HOLD_W = $clog2(HOLD_MS + 1);

   state_t              cur, nxt;
   logic [PWM_BITS-1:0] duty_reg, duty_nxt, cnt, shadow_nxt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                stop_pend, pend_nxt;
   logic                us_tick, step_tick, ms_tick, hold_done, clr;

   assign busy  = (cur != IDLE);
   assign state = cur;
   // Timebase restarts on entry to every state so each dwell is measured from its start.
   assign clr   = (cur == IDLE) || (nxt != cur);
   assign hold_done = us_tick && ms_tick && (hold_cnt == HOLD_W'(HOLD_MS - 1));

   pwm_timebase #(
      .CLK_MHZ (CLK_MHZ),
      .STEP_US (STEP_US)
   ) u_timebase (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .us_tick   (us_tick),
      .step_tick (step_tick),
      .ms_tick   (ms_tick)
   );

   // NOTE: defaults first so no path through the case leaves a latch.
   always_comb begin
      nxt      = cur;
      duty_nxt = duty_reg;
      pend_nxt = stop_pend || (stop && cur != IDLE);
      unique case (cur)
         IDLE: if (start && !stop) nxt = RAMP_UP;
         RAMP_UP: begin
            if (stop) nxt = RAMP_DN;
            else if (step_tick) begin
               if (duty_reg == DUTY_MAX) nxt = HOLD_HI;
               else duty_nxt = duty_reg + 1'b1;
            end
         end
         HOLD_HI: if (stop || hold_done) nxt = RAMP_DN;
         RAMP_DN: begin
            if (step_tick) begin
               if (duty_reg == '0) nxt = HOLD_LO;
               else duty_nxt = duty_reg - 1'b1;
            end
         end
         HOLD_LO: begin
            if (hold_done) begin
               if (pend_nxt) begin
                  nxt      = IDLE;
                  pend_nxt = 1'b0;
               end else begin
                  nxt = RAMP_UP;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end

`ifdef PWM_GAMMA_EN
   logic [2*PWM_BITS-1:0] duty_sq;
   assign duty_sq    = duty_reg * duty_reg;
   assign shadow_nxt = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
   assign shadow_nxt = duty_reg;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cur        <= IDLE;
         duty_reg   <= '0;
         stop_pend  <= 1'b0;
         hold_cnt   <= '0;
         cycle_done <= 1'b0;
         cnt        <= '0;
         duty       <= '0;
         pwm_sig    <= 1'b0;
      end else begin
         cur        <= nxt;
         duty_reg   <= duty_nxt;
         stop_pend  <= pend_nxt;
         hold_cnt   <= clr ? '0 : (ms_tick ? hold_cnt + 1'b1 : hold_cnt);
         cycle_done <= (cur == HOLD_LO) && hold_done;
         // Counter sits at zero through IDLE so the first busy clock starts a fresh period.
         cnt        <= (!busy || nxt == IDLE) ? '0 : cnt + 1'b1;
         if (cnt == DUTY_MAX) duty <= shadow_nxt;
         pwm_sig    <= busy && (cnt < duty);
      end
   end

endmodule
